// File: rtl/hc_sr04_distance.sv
// rtl/hc_sr04_distance.sv - HC-SR04 echo pulse counter with moving average and binary-to-BCD conversion
module hc_sr04_distance #(
   parameter int CNT_WIDTH  = 9,
   parameter int MAX_DIST   = 400,
   parameter int AVG_LOG2   = 2,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_measure_sm,
   input  logic                    i_measure_end,
   output logic [CNT_WIDTH-1:0]    o_dist_bin,
   output logic [4*BCD_DIGITS-1:0] o_dist_bcd,
   output logic                    o_dist_valid,
   output logic                    o_overflow,
   output logic                    o_busy
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = CNT_WIDTH + AVG_LOG2;
   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int SR_W  = BCD_W + CNT_WIDTH;
   localparam int IT_W  = $clog2(CNT_WIDTH + 1);

   localparam logic [CNT_WIDTH-1:0] MAX_C   = CNT_WIDTH'(MAX_DIST);
   localparam logic [IT_W-1:0]      LAST_IT = IT_W'(CNT_WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AVG  = 2'd1;
   localparam logic [1:0] S_CONV = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]           r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_sat;
   logic [CNT_WIDTH-1:0] r_sample;
   logic                 r_sample_ovf;
   logic [CNT_WIDTH-1:0] r_hist [DEPTH];
   logic [SUM_W-1:0]     r_sum;
   logic                 r_first;
   logic [CNT_WIDTH-1:0] r_avg;
   logic [SR_W-1:0]      r_sr;
   logic [IT_W-1:0]      r_iter;
   logic [CNT_WIDTH-1:0] r_dist_bin;
   logic [BCD_W-1:0]     r_dist_bcd;
   logic                 r_overflow;

   logic [SUM_W-1:0]     w_sum_new;
   logic [CNT_WIDTH-1:0] w_avg;
   logic [SR_W-1:0]      w_adj;
   logic [SR_W-1:0]      w_shift;

   // The first sample after reset prefills the whole window so the average starts at that sample.
   always_comb begin
      w_sum_new = '0;
      if (r_first)
         w_sum_new = SUM_W'(r_sample) << AVG_LOG2;
      else
         w_sum_new = r_sum - SUM_W'(r_hist[DEPTH-1]) + SUM_W'(r_sample);
      w_avg = w_sum_new[SUM_W-1:AVG_LOG2];
   end

   // One shift-add-3 step: correct every BCD nibble, then shift the combined register left.
   always_comb begin
      w_adj = r_sr;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (r_sr[CNT_WIDTH+4*d +: 4] >= 4'd5)
            w_adj[CNT_WIDTH+4*d +: 4] = r_sr[CNT_WIDTH+4*d +: 4] + 4'd3;
      end
      w_shift = {w_adj[SR_W-2:0], 1'b0};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_sat        <= 1'b0;
         r_sample     <= '0;
         r_sample_ovf <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
         r_sum        <= '0;
         r_first      <= 1'b1;
         r_avg        <= '0;
         r_sr         <= '0;
         r_iter       <= '0;
         r_dist_bin   <= '0;
         r_dist_bcd   <= '0;
         r_overflow   <= 1'b0;
      end else begin
         // End of measurement always clears the counter, even when the capture is dropped.
         if (i_measure_end) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (i_measure_sm) begin
            if (r_cnt < MAX_C) r_cnt <= r_cnt + 1'b1;
            else               r_sat <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (i_measure_end) begin
                  r_sample     <= r_cnt;
                  r_sample_ovf <= r_sat;
                  r_state      <= S_AVG;
               end
            end
            S_AVG: begin
               if (r_first) begin
                  for (int i = 0; i < DEPTH; i++) r_hist[i] <= r_sample;
               end else begin
                  r_hist[0] <= r_sample;
                  for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
               end
               r_first <= 1'b0;
               r_sum   <= w_sum_new;
               r_avg   <= w_avg;
               r_sr    <= {{BCD_W{1'b0}}, w_avg};
               r_iter  <= '0;
               r_state <= S_CONV;
            end
            S_CONV: begin
               r_sr <= w_shift;
               if (r_iter == LAST_IT) begin
                  r_dist_bin <= r_avg;
                  r_dist_bcd <= w_shift[SR_W-1 -: BCD_W];
                  r_overflow <= r_sample_ovf;
                  r_state    <= S_DONE;
               end else begin
                  r_iter <= r_iter + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_dist_bin   = r_dist_bin;
   assign o_dist_bcd   = r_dist_bcd;
   assign o_overflow   = r_overflow;
   assign o_dist_valid = (r_state == S_DONE);
   assign o_busy       = (r_state != S_IDLE);

endmodule
